schoolbook_digit_serial: RTL and testbench
==========================================

Name: schoolbook_digit_serial

Overview:
- Parametrised digit-serial schoolbook multiplier and the successor to the bit-serial shift-add multiplier.
- Each cycle it consumes one DW-bit digit of operand b, forms a partial product with operand a, and accumulates it at the digit's weight.
- Adds a start/ready/done handshake, operand latching and a stable result register, so it can be sequenced by a top-level controller in the large-integer arithmetic datapath.

Parameters:
- AW, 384, width of operand a in bits.
- BW, 384, width of operand b in bits.
- DW, 8, digit width of b processed per cycle; must divide BW exactly (elaboration error otherwise).
- Derived: ND = BW/DW digits; CW = ceil(log2(ND+1)) digit-counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled only while ready=1.
- a  input  AW  multiplicand; captured on accepted start.
- b  input  BW  multiplier; captured on accepted start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse: c holds a new product.
- c  output  AW+BW  product a*b, held until the next completion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, done=0, c=0, accumulator=0, digit counter=0, latched operands=0. Reset during RUN aborts the operation; no done pulse is produced for it.
- State IDLE:
  - ready=1.
  - start=1 at a rising edge latches a_reg=a and b_reg=b, clears the accumulator and counter, and moves to RUN.
  - start=0 keeps IDLE.
- State RUN:
  - ready=0.
  - Each edge: acc <= acc + ((a_reg * b_reg[DW*k +: DW]) << (DW*k)), k=counter; then counter <= counter+1.
  - Partial product is AW+DW bits; acc is AW+BW bits; no overflow is possible, so no truncation logic is needed.
  - At the edge processing k=ND-1: c <= final sum (acc plus last partial product), done <= 1, state <= IDLE.
- Latency: start accepted at edge E0; the digits are processed at edges E1..E_ND; done=1 and c valid in the cycle after edge E_ND.
  - Total ND+1 edges from acceptance (DW=8, BW=384: 49 cycles).
- done is high for exactly one cycle and is cleared at the next edge.
- c changes only at completion. During a computation c keeps the previous result.
- Back-to-back operation: ready=1 in the same cycle as done=1. A start in that cycle is accepted, and the next done follows ND+1 cycles later.
- start while in RUN is ignored; the operation in progress and the latched operands are unaffected.
- a and b may change freely after the acceptance edge; only the latched copies are used.
- Zero digits are not skipped; latency is data-independent (constant-time).

Test Plan:
- Reset then idle, default parameters -> ready=1, done=0, c=0; start held low for 100 cycles -> outputs unchanged.
- Default params, a=b=2^384-1, one-cycle start -> done pulses exactly 49 cycles after the accepting edge; c=2^768-2^385+1; ready=0 for cycles 1..48.
- Zero and identity operands:
  - a=0, b=2^384-1 -> c=0.
  - a=0x1234_5678_9ABC, b=1 -> c=0x1234_5678_9ABC.
  - Both take 49 cycles.
- AW=BW=16, DW=4, back-to-back runs:
  - Run 1: a=0xFFFF, b=0xFFFF -> done at cycle 5, c=0xFFFE0001.
  - Run 2: start in the done cycle with a=0x00FF, b=0x0100 -> done at cycle 10, c=0x0000FF00.
  - c holds 0xFFFE0001 throughout run 2.
- AW=BW=16, DW=4, disturbed run:
  - Start with a=3, b=5, then drive start=1 with a=7, b=7 during RUN -> done once, c=15, with no extra done.
  - Separate run: assert rst=0 at cycle 2 of RUN -> immediately c=0, ready=1, and no done pulse follows.
- Randomised check, AW=256, BW=128, DW=16 (ND=8): 1000 random operand pairs compared against a reference product -> c matches every time, and latency is always 9 cycles.

Source files
------------

// File: rtl/schoolbook_digit_serial_if.sv
// Handshake and operand/result bundle for the digit-serial schoolbook multiplier.
// The master (controller) drives start and the operands; the slave (multiplier)
// returns ready, the done pulse and the held product.
interface schoolbook_digit_serial_if #(
    parameter int AW = 384,
    parameter int BW = 384
);
    logic              start;
    logic [AW-1:0]     a;
    logic [BW-1:0]     b;
    logic              ready;
    logic              done;
    logic [AW+BW-1:0]  c;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  done,
        input  c
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output done,
        output c
    );
endinterface

// File: rtl/schoolbook_digit_serial.sv
// Digit-serial schoolbook multiplier: one DW-bit digit of b per cycle is
// multiplied by the full a and accumulated at that digit's weight. Operands are
// latched on an accepted start, the product is published in a held result
// register together with a one-cycle done pulse. Latency is data-independent:
// ND+1 edges from acceptance to the cycle in which done is high.
module schoolbook_digit_serial #(
    parameter int AW = 384,
    parameter int BW = 384,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    schoolbook_digit_serial_if.slave bus
);

    localparam int ND = BW / DW;
    localparam int CW = $clog2(ND + 1);
    localparam int PW = AW + DW;
    localparam int RW = AW + BW;

    // Digits must tile b exactly, otherwise the top digit would be partial.
    if ((BW % DW) != 0) begin : g_bad_digit_width
        $error("schoolbook_digit_serial: DW must divide BW exactly");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   c_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            ready;

    logic [BW-1:0]   b_shr;
    logic [DW-1:0]   digit;
    logic [PW-1:0]   pp;
    logic [RW-1:0]   pp_weighted;
    logic [RW-1:0]   sum;
    logic            last_digit;

    // Current digit, its partial product and the running sum including it.
    // Shifting b down (rather than a variable part-select) keeps the select in
    // range even when the counter has run past the last digit in IDLE.
    assign b_shr       = b_q >> (DW * cnt_q);
    assign digit       = b_shr[DW-1:0];
    assign pp          = PW'(a_q) * PW'(digit);
    // NOTE: a*digit fits in AW+DW bits and the sum of all weighted partial
    // products fits in AW+BW bits, so neither needs overflow handling.
    assign pp_weighted = RW'(pp) << (DW * cnt_q);
    assign sum         = acc_q + pp_weighted;
    assign last_digit  = (cnt_q == CW'(ND - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept start only in IDLE, leave RUN after the last digit.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_digit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready is a pure decode of the state.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: operand capture, digit accumulation, result publish and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: these are plain registers, not a memory, so every one of them is
        // cleared by reset; an aborted run leaves nothing stale behind.
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_digit) begin
                        c_q    <= sum;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready;
    assign bus.done  = done_q;
    assign bus.c     = c_q;

endmodule

// File: tb/tb_schoolbook_digit_serial.sv
// Directed bench for schoolbook_digit_serial in three configurations:
// default 384x384/8, a small 16x16/4 for handshake corner cases, and 256x128/16
// for a larger batch of operand pairs against a reference product.
module tb_schoolbook_digit_serial;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    schoolbook_digit_serial_if #(.AW(384), .BW(384)) big_if ();
    schoolbook_digit_serial_if #(.AW(16),  .BW(16))  sm_if ();
    schoolbook_digit_serial_if #(.AW(256), .BW(128)) rn_if ();

    schoolbook_digit_serial #(.AW(384), .BW(384), .DW(8)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (big_if)
    );

    schoolbook_digit_serial #(.AW(16), .BW(16), .DW(4)) u_sm (
        .clk (clk),
        .rst (rst),
        .bus (sm_if)
    );

    schoolbook_digit_serial #(.AW(256), .BW(128), .DW(16)) u_rn (
        .clk (clk),
        .rst (rst),
        .bus (rn_if)
    );

    // Start one run on the default-size DUT; returns the cycle in which done was
    // seen (start cycle = 0) or -1 on timeout. Optionally checks ready=0 in RUN.
    task automatic big_run(input logic [383:0] a, input logic [383:0] b,
                           input bit chk_ready, output int lat);
        big_if.start = 1'b1;
        big_if.a     = a;
        big_if.b     = b;
        @(negedge clk);
        big_if.start = 1'b0;
        big_if.a     = ~a;
        big_if.b     = ~b;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            if (big_if.done === 1'b1) begin
                lat = n;
                break;
            end
            if (chk_ready) begin
                checks++;
                if (big_if.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL big_ready_in_run cycle %0d: got %b want 0", n, big_if.ready);
                end
            end
            @(negedge clk);
        end
    endtask

    // Wait for done on the small DUT; returns cycles waited or -1 on timeout.
    task automatic sm_wait(input logic [31:0] hold_c, input bit chk_hold, output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (sm_if.done === 1'b1) begin
                lat = n;
                break;
            end
            if (chk_hold) begin
                checks++;
                if (sm_if.c !== hold_c) begin
                    errors++;
                    $display("FAIL sm_c_hold cycle %0d: got %h want %h", n, sm_if.c, hold_c);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b0;
        big_if.start = 1'b0; big_if.a = '0; big_if.b = '0;
        sm_if.start  = 1'b0; sm_if.a  = '0; sm_if.b  = '0;
        rn_if.start  = 1'b0; rn_if.a  = '0; rn_if.b  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (big_if.ready !== 1'b1 || big_if.done !== 1'b0 || big_if.c !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b c=%h want ready=1 done=0 c=0",
                     big_if.ready, big_if.done, big_if.c);
        end
        checks++;
        if (sm_if.ready !== 1'b1 || sm_if.done !== 1'b0 || sm_if.c !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_small: ready=%b done=%b c=%h want 1 0 0",
                     sm_if.ready, sm_if.done, sm_if.c);
        end
        bad = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (big_if.ready !== 1'b1 || big_if.done !== 1'b0 || big_if.c !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_100_cycles: outputs changed while start low, got ready=%b done=%b",
                     big_if.ready, big_if.done);
        end
    endtask

    task automatic test_max_operands();
        int lat;
        logic [767:0] exp_c;
        exp_c = {{383{1'b1}}, {384{1'b0}}, 1'b1};
        big_run({384{1'b1}}, {384{1'b1}}, 1'b1, lat);
        checks++;
        if (lat != 49) begin
            errors++;
            $display("FAIL max_latency: got %0d want 49", lat);
        end
        checks++;
        if (big_if.c !== exp_c) begin
            errors++;
            $display("FAIL max_product: got %h want %h", big_if.c, exp_c);
        end
        checks++;
        if (big_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL max_ready_at_done: got %b want 1", big_if.ready);
        end
        @(negedge clk);
        checks++;
        if (big_if.done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_cycle: got %b want 0", big_if.done);
        end
    endtask

    task automatic test_zero_identity();
        int lat;
        logic [767:0] exp_c;
        big_run('0, {384{1'b1}}, 1'b0, lat);
        checks++;
        if (lat != 49 || big_if.c !== '0) begin
            errors++;
            $display("FAIL zero_operand: lat=%0d c=%h want lat=49 c=0", lat, big_if.c);
        end
        @(negedge clk);
        exp_c = 768'h1234_5678_9ABC;
        big_run(384'h1234_5678_9ABC, 384'h1, 1'b0, lat);
        checks++;
        if (lat != 49 || big_if.c !== exp_c) begin
            errors++;
            $display("FAIL identity_operand: lat=%0d c=%h want lat=49 c=%h", lat, big_if.c, exp_c);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        sm_if.start = 1'b1; sm_if.a = 16'hFFFF; sm_if.b = 16'hFFFF;
        @(negedge clk);
        sm_if.start = 1'b0; sm_if.a = 16'h0; sm_if.b = 16'h0;
        sm_wait(32'h0, 1'b0, lat1);
        checks++;
        if (lat1 != 5 || sm_if.c !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL b2b_run1: lat=%0d c=%h want lat=5 c=fffe0001", lat1, sm_if.c);
        end
        checks++;
        if (sm_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_with_done: got %b want 1", sm_if.ready);
        end
        // Start the second run in the done cycle of the first.
        sm_if.start = 1'b1; sm_if.a = 16'h00FF; sm_if.b = 16'h0100;
        @(negedge clk);
        sm_if.start = 1'b0; sm_if.a = 16'h1111; sm_if.b = 16'h2222;
        sm_wait(32'hFFFE0001, 1'b1, lat2);
        checks++;
        if (lat1 + lat2 != 10 || sm_if.c !== 32'h0000FF00) begin
            errors++;
            $display("FAIL b2b_run2: done cycle=%0d c=%h want cycle=10 c=0000ff00",
                     lat1 + lat2, sm_if.c);
        end
        @(negedge clk);
    endtask

    task automatic test_disturbed();
        int lat;
        bit extra;
        sm_if.start = 1'b1; sm_if.a = 16'd3; sm_if.b = 16'd5;
        @(negedge clk);
        sm_if.a = 16'd7; sm_if.b = 16'd7;   // start stays high during RUN
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (sm_if.done === 1'b1) begin
                lat = n;
                break;
            end
            if (n == 4) sm_if.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (lat != 5 || sm_if.c !== 32'd15) begin
            errors++;
            $display("FAIL start_in_run_ignored: lat=%0d c=%h want lat=5 c=0000000f", lat, sm_if.c);
        end
        extra = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (sm_if.done !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL no_extra_done: got an extra done pulse, want none");
        end
    endtask

    task automatic test_reset_in_run();
        bit extra;
        sm_if.start = 1'b1; sm_if.a = 16'hFFFF; sm_if.b = 16'hFFFF;
        @(negedge clk);
        sm_if.start = 1'b0;
        @(negedge clk);                     // cycle 2 of RUN
        rst = 1'b0;
        #1;
        checks++;
        if (sm_if.c !== 32'h0 || sm_if.ready !== 1'b1 || sm_if.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run: c=%h ready=%b done=%b want c=0 ready=1 done=0",
                     sm_if.c, sm_if.ready, sm_if.done);
        end
        @(negedge clk);
        rst = 1'b1;
        extra = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (sm_if.done !== 1'b0 || sm_if.c !== 32'h0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL no_done_after_abort: done=%b c=%h want done=0 c=0", sm_if.done, sm_if.c);
        end
    endtask

    task automatic test_random_pairs();
        logic [255:0] ra;
        logic [127:0] rb;
        logic [383:0] exp_c;
        int lat;
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < 8; i++) ra[32*i +: 32] = $urandom();
            for (int i = 0; i < 4; i++) rb[32*i +: 32] = $urandom();
            if (it == 0) begin ra = '1; rb = '1; end
            if (it == 1) begin rb = '0; end
            exp_c = {128'b0, ra} * {256'b0, rb};
            rn_if.start = 1'b1; rn_if.a = ra; rn_if.b = rb;
            @(negedge clk);
            rn_if.start = 1'b0; rn_if.a = ~ra; rn_if.b = ~rb;
            lat = -1;
            for (int n = 1; n <= 20; n++) begin
                if (rn_if.done === 1'b1) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL rand_latency it %0d: got %0d want 9", it, lat);
            end
            checks++;
            if (rn_if.c !== exp_c) begin
                errors++;
                $display("FAIL rand_product it %0d: got %h want %h", it, rn_if.c, exp_c);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_zero_identity();
        test_back_to_back();
        test_disturbed();
        test_reset_in_run();
        test_random_pairs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
